// File: rtl/branch_update_queue.sv
// ---------------------------------------------------------------------------
// branch_update_queue
//   In-order tracker for branches predicted by the local 2-bit saturating-
//   counter predictor. The frontend allocates an entry per predicted branch.
//   Execute resolves entries out of order by tag. Resolved entries retire
//   oldest-first, one per cycle, as a counter-update request to the predictor.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             squash every in-flight entry (pipeline redirect)
//   alloc_*           allocation handshake; alloc_tag is the slot being given
//   resolve_*         out-of-order outcome report by tag
//   upd_*             registered predictor update request (upd_valid strobe)
//
// Optional feature (macro BRANCH_UPDATE_QUEUE_STATS_EN)
//   stat_commits, stat_mispredicts: saturating 16-bit event counters.
// ---------------------------------------------------------------------------
module branch_update_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 10,
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [PC_W-1:0]  alloc_pc,
  input  logic [1:0]       alloc_counter,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [1:0]       upd_counter,
  output logic             upd_valid,
  output logic             upd_mispredict
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
  ,
  output logic [15:0]      stat_commits,
  output logic [15:0]      stat_mispredicts
`endif
);

  localparam int unsigned PTR_W  = TAG_W + 1;
  localparam int unsigned CTR_W  = 2;
  localparam int unsigned STAT_W = 16;

  // Per-entry storage
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_resolved;
  logic [DEPTH-1:0] r_taken;
  logic [PC_W-1:0]  r_pc      [DEPTH];
  logic [CTR_W-1:0] r_counter [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;

  // Registered update request
  logic [PC_W-1:0]  r_upd_pc;
  logic             r_upd_taken;
  logic [CTR_W-1:0] r_upd_counter;
  logic             r_upd_valid;
  logic             r_upd_mispredict;

  logic [PTR_W-1:0] w_count;
  logic [TAG_W-1:0] w_head_idx;
  logic [TAG_W-1:0] w_tail_idx;
  logic             w_alloc_fire;
  logic             w_resolve_fire;
  logic             w_commit_fire;
  logic             w_commit_mispredict;

  // Occupancy and handshake, all from registered state
  assign w_count     = r_tail - r_head;
  assign w_head_idx  = r_head[TAG_W-1:0];
  assign w_tail_idx  = r_tail[TAG_W-1:0];
  assign alloc_ready = (w_count < PTR_W'(DEPTH));
  assign alloc_tag   = w_tail_idx;

  // A commit in the same cycle does not free a slot for allocation
  assign w_alloc_fire = alloc_valid & alloc_ready;

  // Only a live, still-unresolved entry accepts an outcome
  assign w_resolve_fire = resolve_valid & r_valid[resolve_tag] & ~r_resolved[resolve_tag];

  // Head retires as soon as it is resolved; an unresolved head blocks the rest
  assign w_commit_fire       = r_valid[w_head_idx] & r_resolved[w_head_idx];
  assign w_commit_mispredict = r_counter[w_head_idx][1] ^ r_taken[w_head_idx];

  // Entry state and pointers; flush squashes everything, allocate is applied
  // last so it wins over a same-index resolve
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid    <= '0;
      r_resolved <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      if (w_resolve_fire) begin
        r_resolved[resolve_tag] <= 1'b1;
      end
      if (w_commit_fire) begin
        r_valid[w_head_idx]    <= 1'b0;
        r_resolved[w_head_idx] <= 1'b0;
        r_head                 <= r_head + PTR_W'(1);
      end
      if (w_alloc_fire) begin
        r_valid[w_tail_idx]    <= 1'b1;
        r_resolved[w_tail_idx] <= 1'b0;
        r_tail                 <= r_tail + PTR_W'(1);
      end
    end
  end

  // Payload storage; writes during a flush land in entries that are
  // being invalidated, so they need no gating
  always_ff @(posedge clk) begin
    if (w_resolve_fire) begin
      r_taken[resolve_tag] <= resolve_taken;
    end
    if (w_alloc_fire) begin
      r_pc[w_tail_idx]      <= alloc_pc;
      r_counter[w_tail_idx] <= alloc_counter;
      r_taken[w_tail_idx]   <= 1'b0;
    end
  end

  // Predictor update request; payload holds between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_taken      <= 1'b0;
      r_upd_counter    <= '0;
      r_upd_mispredict <= 1'b0;
    end else if (flush) begin
      r_upd_valid <= 1'b0;
    end else if (w_commit_fire) begin
      r_upd_valid      <= 1'b1;
      r_upd_pc         <= r_pc[w_head_idx];
      r_upd_taken      <= r_taken[w_head_idx];
      r_upd_counter    <= r_counter[w_head_idx];
      r_upd_mispredict <= w_commit_mispredict;
    end else begin
      r_upd_valid <= 1'b0;
    end
  end

  assign upd_valid      = r_upd_valid;
  assign upd_pc         = r_upd_pc;
  assign upd_taken      = r_upd_taken;
  assign upd_counter    = r_upd_counter;
  assign upd_mispredict = r_upd_mispredict;

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
  logic [STAT_W-1:0] r_stat_commits;
  logic [STAT_W-1:0] r_stat_mispredicts;
  logic              w_stat_event;

  // Counted on the edge that raises upd_valid so the counters track the pulse
  assign w_stat_event = w_commit_fire & ~flush;

  // Saturating event counters; cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_commits     <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_stat_event) begin
      if (r_stat_commits != {STAT_W{1'b1}}) begin
        r_stat_commits <= r_stat_commits + STAT_W'(1);
      end
      if (w_commit_mispredict && (r_stat_mispredicts != {STAT_W{1'b1}})) begin
        r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(1);
      end
    end
  end

  assign stat_commits     = r_stat_commits;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// ---------------------------------------------------------------------------
// tb_branch_update_queue
//   Directed vector table, hand-written corner sequences and randomized
//   traffic checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_branch_update_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PC_W  = 10;
  localparam int unsigned TAG_W = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [PC_W-1:0]  alloc_pc;
  logic [1:0]       alloc_counter;
  logic [TAG_W-1:0] alloc_tag;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [1:0]       upd_counter;
  logic             upd_valid;
  logic             upd_mispredict;
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
  logic [15:0]      stat_commits;
  logic [15:0]      stat_mispredicts;
`endif

  branch_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_pc       (alloc_pc),
    .alloc_counter  (alloc_counter),
    .alloc_tag      (alloc_tag),
    .resolve_valid  (resolve_valid),
    .resolve_tag    (resolve_tag),
    .resolve_taken  (resolve_taken),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_counter    (upd_counter),
    .upd_valid      (upd_valid),
    .upd_mispredict (upd_mispredict)
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    ,
    .stat_commits     (stat_commits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            rst, flush, av;
    logic [PC_W-1:0] apc;
    logic [1:0]      actr;
    logic            rv;
    logic [TAG_W-1:0] rtag;
    logic            rtk;
    logic            e_ready;
    logic [TAG_W-1:0] e_tag;
    logic            e_uv;
    logic [PC_W-1:0] e_upc;
    logic            e_ut;
    logic [1:0]      e_uc;
    logic            e_um;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic av, logic [PC_W-1:0] apc,
                              logic [1:0] actr, logic rv, logic [TAG_W-1:0] rtag,
                              logic rtk, logic er, logic [TAG_W-1:0] et, logic euv,
                              logic [PC_W-1:0] eupc, logic eut, logic [1:0] euc,
                              logic eum);
    vec_t v;
    v.rst = r; v.flush = f; v.av = av; v.apc = apc; v.actr = actr;
    v.rv = rv; v.rtag = rtag; v.rtk = rtk; v.e_ready = er; v.e_tag = et;
    v.e_uv = euv; v.e_upc = eupc; v.e_ut = eut; v.e_uc = euc; v.e_um = eum;
    return v;
  endfunction

  vec_t tbl[16];

  // ---------------- reference model ----------------
  typedef struct {
    logic [PC_W-1:0] pc;
    logic [1:0]      ctr;
    bit              res;
    bit              tk;
  } ment_t;

  ment_t           m_ent[DEPTH];
  int              m_q[$];        // live tags, oldest first
  int              m_next;        // next tag to hand out
  logic            e_uv, e_ut, e_um;
  logic [PC_W-1:0] e_upc;
  logic [1:0]      e_uc;
  int              m_sc, m_sm;

  function automatic bit in_q(int tag);
    foreach (m_q[i]) if (m_q[i] == tag) return 1'b1;
    return 1'b0;
  endfunction

  // One clock with the given inputs; model advances, outputs checked after the edge
  task automatic cycle(input logic r, input logic f, input logic av,
                       input logic [PC_W-1:0] apc, input logic [1:0] actr,
                       input logic rv, input logic [TAG_W-1:0] rtag, input logic rtk);
    bit ready, commit;
    int h;
    rst = r; flush = f; alloc_valid = av; alloc_pc = apc; alloc_counter = actr;
    resolve_valid = rv; resolve_tag = rtag; resolve_taken = rtk;
    ready = (m_q.size() < DEPTH);
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_next = 0;
      e_uv = 0; e_upc = '0; e_ut = 0; e_uc = '0; e_um = 0;
      m_sc = 0; m_sm = 0;
    end else if (f) begin
      m_q.delete(); m_next = 0; e_uv = 0;
    end else begin
      commit = (m_q.size() > 0) && m_ent[m_q[0]].res;
      if (rv && in_q(int'(rtag)) && !m_ent[rtag].res) begin
        m_ent[rtag].res = 1'b1;
        m_ent[rtag].tk  = rtk;
      end
      if (commit) begin
        h = m_q.pop_front();
        e_uv = 1; e_upc = m_ent[h].pc; e_ut = m_ent[h].tk; e_uc = m_ent[h].ctr;
        e_um = m_ent[h].ctr[1] != m_ent[h].tk;
        if (m_sc < 65535) m_sc++;
        if (e_um && m_sm < 65535) m_sm++;
      end else begin
        e_uv = 0;
      end
      if (av && ready) begin
        m_ent[m_next] = '{pc: apc, ctr: actr, res: 1'b0, tk: 1'b0};
        m_q.push_back(m_next);
        m_next = (m_next + 1) % DEPTH;
      end
    end
    #1;
    chk("upd_valid", 32'(upd_valid), 32'(e_uv));
    chk("upd_pc", 32'(upd_pc), 32'(e_upc));
    chk("upd_taken", 32'(upd_taken), 32'(e_ut));
    chk("upd_counter", 32'(upd_counter), 32'(e_uc));
    chk("upd_mispredict", 32'(upd_mispredict), 32'(e_um));
    chk("alloc_ready", 32'(alloc_ready), 32'(m_q.size() < DEPTH));
    if (m_q.size() < DEPTH) chk("alloc_tag", 32'(alloc_tag), 32'(m_next));
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    chk("stat_commits", 32'(stat_commits), 32'(m_sc));
    chk("stat_mispredicts", 32'(stat_mispredicts), 32'(m_sm));
`endif
  endtask

  task automatic do_reset();  cycle(1, 0, 0, '0, '0, 0, '0, 0); endtask
  task automatic do_flush();  cycle(0, 1, 0, '0, '0, 0, '0, 0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, 0, '0, 0);
  endtask
  task automatic alloc(input logic [PC_W-1:0] pc, input logic [1:0] ctr);
    cycle(0, 0, 1, pc, ctr, 0, '0, 0);
  endtask
  task automatic resolve(input logic [TAG_W-1:0] tag, input logic tk);
    cycle(0, 0, 0, '0, '0, 1, tag, tk);
  endtask

  initial begin
    rst = 0; flush = 0; alloc_valid = 0; alloc_pc = '0; alloc_counter = '0;
    resolve_valid = 0; resolve_tag = '0; resolve_taken = 0;

    // Single branch latency, then three out-of-order resolves
    tbl[0]  = mk(1,0,0,'0,   2'd0,0,3'd0,0, 1,3'd0,0,'0,   0,2'd0,0);
    tbl[1]  = mk(0,0,1,'h3A5,2'd1,0,3'd0,0, 1,3'd1,0,'0,   0,2'd0,0);
    tbl[2]  = mk(0,0,0,'0,   2'd0,1,3'd0,1, 1,3'd1,0,'0,   0,2'd0,0);
    tbl[3]  = mk(0,0,0,'0,   2'd0,0,3'd0,0, 1,3'd1,1,'h3A5,1,2'd1,1);
    tbl[4]  = mk(0,0,0,'0,   2'd0,0,3'd0,0, 1,3'd1,0,'h3A5,1,2'd1,1);
    tbl[5]  = mk(1,0,0,'0,   2'd0,0,3'd0,0, 1,3'd0,0,'0,   0,2'd0,0);
    tbl[6]  = mk(0,0,1,'h100,2'd3,0,3'd0,0, 1,3'd1,0,'0,   0,2'd0,0);
    tbl[7]  = mk(0,0,1,'h101,2'd0,0,3'd0,0, 1,3'd2,0,'0,   0,2'd0,0);
    tbl[8]  = mk(0,0,1,'h102,2'd2,0,3'd0,0, 1,3'd3,0,'0,   0,2'd0,0);
    tbl[9]  = mk(0,0,0,'0,   2'd0,1,3'd2,0, 1,3'd3,0,'0,   0,2'd0,0);
    tbl[10] = mk(0,0,0,'0,   2'd0,1,3'd1,1, 1,3'd3,0,'0,   0,2'd0,0);
    tbl[11] = mk(0,0,0,'0,   2'd0,1,3'd0,1, 1,3'd3,0,'0,   0,2'd0,0);
    tbl[12] = mk(0,0,0,'0,   2'd0,0,3'd0,0, 1,3'd3,1,'h100,1,2'd3,0);
    tbl[13] = mk(0,0,0,'0,   2'd0,0,3'd0,0, 1,3'd3,1,'h101,1,2'd0,1);
    tbl[14] = mk(0,0,0,'0,   2'd0,0,3'd0,0, 1,3'd3,1,'h102,0,2'd2,1);
    tbl[15] = mk(0,0,0,'0,   2'd0,0,3'd0,0, 1,3'd3,0,'h102,0,2'd2,1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; flush = tbl[i].flush; alloc_valid = tbl[i].av;
      alloc_pc = tbl[i].apc; alloc_counter = tbl[i].actr;
      resolve_valid = tbl[i].rv; resolve_tag = tbl[i].rtag; resolve_taken = tbl[i].rtk;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d_tag", i), 32'(alloc_tag), 32'(tbl[i].e_tag));
      chk($sformatf("v%0d_uv", i), 32'(upd_valid), 32'(tbl[i].e_uv));
      chk($sformatf("v%0d_upc", i), 32'(upd_pc), 32'(tbl[i].e_upc));
      chk($sformatf("v%0d_ut", i), 32'(upd_taken), 32'(tbl[i].e_ut));
      chk($sformatf("v%0d_uc", i), 32'(upd_counter), 32'(tbl[i].e_uc));
      chk($sformatf("v%0d_um", i), 32'(upd_mispredict), 32'(tbl[i].e_um));
    end

    // Fill, overflow attempt, full-plus-commit, wrap of the tag
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(PC_W'(10'h040 + i), 2'(i));
    chk("full_ready", 32'(alloc_ready), 32'd0);
    alloc(10'h3FF, 2'd3);
    resolve(3'd0, 1'b1);
    chk("full_after_resolve", 32'(alloc_ready), 32'd0);
    alloc(10'h3FE, 2'd3);                     // commit edge: allocation refused
    chk("ready_after_commit", 32'(alloc_ready), 32'd1);
    chk("wrap_tag", 32'(alloc_tag), 32'd0);
    alloc(10'h2AA, 2'd2);
    chk("refull_ready", 32'(alloc_ready), 32'd0);

    // Flush with concurrent allocate and resolve
    do_reset();
    for (int i = 0; i < 4; i++) alloc(PC_W'(10'h200 + i), 2'd1);
    resolve(3'd1, 1'b1);
    resolve(3'd2, 1'b0);
    cycle(0, 1, 1, 10'h155, 2'd2, 1, 3'd3, 1);
    chk("flush_tag", 32'(alloc_tag), 32'd0);
    idle(3);

    // Ignored resolves: repeat with opposite outcome, and never-allocated tag
    do_reset();
    alloc(10'h011, 2'd2);
    alloc(10'h022, 2'd1);
    resolve(3'd1, 1'b1);
    resolve(3'd1, 1'b0);
    resolve(3'd5, 1'b1);
    resolve(3'd0, 1'b0);
    idle(1);
    idle(1);
    chk("first_outcome_kept", 32'(upd_taken), 32'd1);
    idle(2);

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    // Five commits, two mispredicted; flush does not touch the counters
    do_reset();
    alloc(10'h001, 2'd3); alloc(10'h002, 2'd3); alloc(10'h003, 2'd0);
    alloc(10'h004, 2'd0); alloc(10'h005, 2'd2);
    resolve(3'd0, 1); resolve(3'd1, 0); resolve(3'd2, 0);
    resolve(3'd3, 1); resolve(3'd4, 1);
    idle(3);
    chk("stats_commits5", 32'(stat_commits), 32'd5);
    chk("stats_mis2", 32'(stat_mispredicts), 32'd2);
    do_flush();
    chk("stats_commits_flush", 32'(stat_commits), 32'd5);
    chk("stats_mis_flush", 32'(stat_mispredicts), 32'd2);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic r, f, av, rv, tk;
      logic [TAG_W-1:0] tg;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 79) == 0);
      av = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 60);
      tk = 1'($urandom);
      if (m_q.size() > 0 && $urandom_range(0, 9) < 8)
        tg = TAG_W'(m_q[$urandom_range(0, m_q.size() - 1)]);
      else
        tg = TAG_W'($urandom);
      cycle(r, f, av, PC_W'($urandom), 2'($urandom), rv, tg, tk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
